cprv_mem_arbiter: RTL and testbench
===================================

CPRV_MEM_ARBITER -- requirements
Module: cprv_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, meaning memory byte-address width passed to the 1-port memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning data width; byte-strobe width is DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports if_req_valid in 1, if_req_ready out 1, if_req_addr in ADDR_WIDTH  fetch request, read-only.
REQ-006 SHALL have ports if_rsp_valid out 1, if_rsp_data out DATA_WIDTH  fetch response.
REQ-007 SHALL have ports d_req_valid in 1, d_req_ready out 1, d_req_we in 1, d_req_addr in ADDR_WIDTH, d_req_wdata in DATA_WIDTH, d_req_wstrb in DATA_WIDTH/8  data request.
REQ-008 SHALL have ports d_rsp_valid out 1, d_rsp_data out DATA_WIDTH  data response.
REQ-009 SHALL have ports mem_w_en out 1, mem_addr out ADDR_WIDTH, mem_wdata out DATA_WIDTH, mem_rdata in DATA_WIDTH  1-port memory; memory has 1-cycle read latency and echoes wdata on rdata when writing.

Function
REQ-010 SHALL implement states IDLE, RESP, RMW_WR; at most one transaction in flight.
REQ-011 SHALL assert a req_ready only in IDLE or RESP, and only to the granted port; a request is accepted when valid&&ready.
REQ-012 SHALL, on simultaneous valid (no CPRV_ARB_RR_EN), grant the data port; fetch ready=0 that cycle.
REQ-013 SHALL, in the accept cycle, drive mem_addr=request addr combinationally; mem_w_en=0 when ready=0 or no accept.
REQ-014 SHALL handle read (fetch, or d_req_we=0, or wstrb==0): mem_w_en=0, next state RESP.
REQ-015 SHALL handle full write (wstrb all ones): mem_w_en=1, mem_wdata=d_req_wdata in accept cycle, next state RESP.
REQ-016 SHALL handle partial write: read issued in accept cycle, addr/wdata/wstrb registered; RMW_WR next cycle drives mem_w_en=1, mem_addr=saved addr, mem_wdata=per-byte mux(wstrb ? saved wdata : mem_rdata); then RESP.
REQ-017 SHALL, in RESP, pulse the owning port's rsp_valid for exactly one cycle with rsp_data=mem_rdata; other port's rsp_valid=0.
REQ-018 SHALL give latency accept->rsp_valid of 1 cycle (read/full write) and 2 cycles (partial write).
REQ-019 SHALL allow a new accept in RESP (back-to-back throughput 1 per cycle for reads/full writes); RESP with no accept returns to IDLE.
REQ-020 SHALL deassert both req_ready in RMW_WR.
REQ-021 SHALL keep rsp_data outputs equal to mem_rdata when rsp_valid=0 (don't-care for consumers).

Reset
REQ-022 SHALL, while rst=1, force state IDLE, both rsp_valid=0, mem_w_en=0, both req_ready=0, round-robin pointer=fetch-last.
REQ-023 SHALL drop any in-flight transaction on reset: no response issued, no RMW_WR write performed.

Configuration
REQ-024 SHALL compile round-robin arbitration when macro CPRV_ARB_RR_EN is defined: on conflict, grant the port not granted last; pointer updates on every accept.
REQ-025 SHALL use fixed data-over-fetch priority when CPRV_ARB_RR_EN is undefined; fetch starvation is permitted.

Verification
REQ-026 SHALL cover: fetch read addr 0x08 with memory holding 0x13 -> if_rsp_valid 1 cycle later, if_rsp_data=0x13, d_rsp_valid=0.
REQ-027 SHALL cover: data write addr 0x10 wdata 0x1122334455667788 wstrb 0xFF -> mem_w_en=1 same cycle, d_rsp_data=0x1122334455667788 next cycle.
REQ-028 SHALL cover: memory word 0xFFFFFFFFFFFFFFFF, write wdata 0, wstrb 0x0F -> mem_w_en only in RMW_WR, mem_wdata=0xFFFFFFFF00000000, d_rsp_valid 2 cycles after accept.
REQ-029 SHALL cover: both valid 4 consecutive cycles -> without macro grants D,D,D,D; with CPRV_ARB_RR_EN grants D,F,D,F.
REQ-030 SHALL cover: rst=1 in RMW_WR cycle -> mem_w_en=0, no d_rsp_valid, memory word unchanged, state IDLE.
REQ-031 SHALL cover: 3 back-to-back fetch reads addrs 0,4,8 -> 3 consecutive if_rsp_valid cycles, data in order.

Source files
------------

// File: rtl/cprv_mem_arbiter.sv
// cprv_mem_arbiter
// Arbitrates a read-only instruction-fetch port and a read/write data port
// onto a single-ported memory with 1-cycle read latency. At most one
// transaction is in flight. Reads and full-word writes return a response
// one cycle after acceptance. Partial writes take two cycles: a read, then
// a merged write-back.
//
// Build option: define CPRV_ARB_RR_EN to use round-robin arbitration
// between the two ports. Without it, the data port always wins a conflict.

module cprv_mem_arbiter #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,

    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic                    d_req_we,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    output logic                    d_rsp_valid,
    output logic [DATA_WIDTH-1:0]   d_rsp_data,

    output logic                    mem_w_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP   = 2'd1,
        RMW_WR = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Owner of the transaction whose response is pending (1 = data port).
    logic owner_d;
    logic owner_d_next;

    // Request fields held across the read half of a read-modify-write.
    logic [ADDR_WIDTH-1:0] saved_addr;
    logic [DATA_WIDTH-1:0] saved_wdata;
    logic [STRB_WIDTH-1:0] saved_wstrb;

`ifdef CPRV_ARB_RR_EN
    // Round-robin pointer: set when the data port won the last accept.
    logic last_grant_d;
`endif

    logic                  can_accept;
    logic                  grant_d;
    logic                  accept_f;
    logic                  accept_d;
    logic                  d_is_write;
    logic                  d_full_write;
    logic                  d_partial_write;
    logic [DATA_WIDTH-1:0] rmw_merged;

    // Arbitration: decide which port is offered ready this cycle.
    always_comb begin
        can_accept = !rst && ((state == IDLE) || (state == RESP));
`ifdef CPRV_ARB_RR_EN
        grant_d = d_req_valid && !(if_req_valid && last_grant_d);
`else
        grant_d = d_req_valid;
`endif
        if_req_ready = can_accept && !grant_d;
        d_req_ready  = can_accept && grant_d;
        accept_f     = if_req_valid && if_req_ready;
        accept_d     = d_req_valid && d_req_ready;
    end

    // Classify the data request: a zero strobe or we=0 is treated as a read.
    always_comb begin
        d_is_write      = d_req_we && (d_req_wstrb != '0);
        d_full_write    = d_is_write && (&d_req_wstrb);
        d_partial_write = d_is_write && !(&d_req_wstrb);
    end

    // Byte merge for the write-back half of a partial write.
    always_comb begin
        rmw_merged = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            rmw_merged[i*8 +: 8] = saved_wstrb[i] ? saved_wdata[i*8 +: 8]
                                                  : mem_rdata[i*8 +: 8];
        end
    end

    // Next-state, memory-port and response control.
    always_comb begin
        state_next   = IDLE;
        owner_d_next = owner_d;
        mem_w_en     = 1'b0;
        mem_addr     = saved_addr;
        mem_wdata    = d_req_wdata;
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;

        if (!rst) begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                RESP: begin
                    if_rsp_valid = !owner_d;
                    d_rsp_valid  = owner_d;
                    state_next   = IDLE;
                end
                RMW_WR: begin
                    mem_w_en   = 1'b1;
                    mem_addr   = saved_addr;
                    mem_wdata  = rmw_merged;
                    state_next = RESP;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            if (accept_d) begin
                owner_d_next = 1'b1;
                mem_addr     = d_req_addr;
                mem_w_en     = d_full_write;
                mem_wdata    = d_req_wdata;
                state_next   = d_partial_write ? RMW_WR : RESP;
            end else if (accept_f) begin
                owner_d_next = 1'b0;
                mem_addr     = if_req_addr;
                state_next   = RESP;
            end
        end
    end

    // Response data simply mirrors the memory read bus.
    always_comb begin
        if_rsp_data = mem_rdata;
        d_rsp_data  = mem_rdata;
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner_d <= 1'b0;
        end else begin
            state   <= state_next;
            owner_d <= owner_d_next;
        end
    end

    // Capture partial-write fields for the write-back cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            saved_addr  <= '0;
            saved_wdata <= '0;
            saved_wstrb <= '0;
        end else if (accept_d && d_partial_write) begin
            saved_addr  <= d_req_addr;
            saved_wdata <= d_req_wdata;
            saved_wstrb <= d_req_wstrb;
        end
    end

`ifdef CPRV_ARB_RR_EN
    // Round-robin pointer follows every accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b0;
        end else if (accept_d || accept_f) begin
            last_grant_d <= accept_d;
        end
    end
`endif

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Testbench for cprv_mem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model of the arbiter and a
// shadow copy of memory.

module tb_cprv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [6:0]  if_req_addr;
    logic        if_rsp_valid;
    logic [63:0] if_rsp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic        d_req_we;
    logic [6:0]  d_req_addr;
    logic [63:0] d_req_wdata;
    logic [7:0]  d_req_wstrb;
    logic        d_rsp_valid;
    logic [63:0] d_rsp_data;
    logic        mem_w_en;
    logic [6:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    // Memory contents as the bench's memory holds them, and as expected.
    logic [63:0] tb_mem  [16] = '{default: '0};
    logic [63:0] ref_mem [16] = '{default: '0};

    // Transaction-level model state.
    int          rsp_cnt  = 0;
    bit          rsp_is_d = 1'b0;
    logic [63:0] rsp_word = '0;
    bit          rmw_pend = 1'b0;
    logic [6:0]  rmw_addr = '0;
    logic [63:0] rmw_word = '0;
    bit          last_d   = 1'b0;

    cprv_mem_arbiter #(.ADDR_WIDTH(7), .DATA_WIDTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_wstrb  (d_req_wstrb),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .mem_w_en     (mem_w_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: 1-cycle read latency, echoes write data.
    always @(posedge clk) begin
        if (mem_w_en) begin
            tb_mem[mem_addr[6:3]] <= mem_wdata;
            mem_rdata             <= mem_wdata;
        end else begin
            mem_rdata <= tb_mem[mem_addr[6:3]];
        end
    end

    function automatic logic [63:0] mergeBytes(input logic [63:0] old_w,
                                               input logic [63:0] new_w,
                                               input logic [7:0]  strb);
        logic [63:0] r;
        r = old_w;
        for (int i = 0; i < 8; i++)
            if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and check every output against the model.
    task automatic applyStimulus(input logic r, input logic ifv,
                                 input logic [6:0] ifa, input logic dv,
                                 input logic we, input logic [6:0] da,
                                 input logic [63:0] wd, input logic [7:0] ws);
        bit          gd, acc_d, acc_f, full_wr, part_wr;
        logic [63:0] cur;
        @(negedge clk);
        rst          = r;
        if_req_valid = ifv;
        if_req_addr  = ifa;
        d_req_valid  = dv;
        d_req_we     = we;
        d_req_addr   = da;
        d_req_wdata  = wd;
        d_req_wstrb  = ws;
        #1;
        if (r) begin
            checkOutput("rst_if_ready", {63'd0, if_req_ready}, 64'd0);
            checkOutput("rst_d_ready", {63'd0, d_req_ready}, 64'd0);
            checkOutput("rst_w_en", {63'd0, mem_w_en}, 64'd0);
            checkOutput("rst_if_rsp_v", {63'd0, if_rsp_valid}, 64'd0);
            checkOutput("rst_d_rsp_v", {63'd0, d_rsp_valid}, 64'd0);
            rsp_cnt  = 0;
            rmw_pend = 1'b0;
            last_d   = 1'b0;
            return;
        end

        checkOutput("if_rsp_v", {63'd0, if_rsp_valid}, {63'd0, (rsp_cnt == 1) && !rsp_is_d});
        checkOutput("d_rsp_v", {63'd0, d_rsp_valid}, {63'd0, (rsp_cnt == 1) && rsp_is_d});
        if (rsp_cnt == 1) begin
            if (rsp_is_d) checkOutput("d_rsp_data", d_rsp_data, rsp_word);
            else          checkOutput("if_rsp_data", if_rsp_data, rsp_word);
        end
        if (rsp_cnt > 0) rsp_cnt--;

        if (rmw_pend) begin
            checkOutput("rmw_if_ready", {63'd0, if_req_ready}, 64'd0);
            checkOutput("rmw_d_ready", {63'd0, d_req_ready}, 64'd0);
            checkOutput("rmw_w_en", {63'd0, mem_w_en}, 64'd1);
            checkOutput("rmw_addr", {57'd0, mem_addr}, {57'd0, rmw_addr});
            checkOutput("rmw_wdata", mem_wdata, rmw_word);
            ref_mem[rmw_addr[6:3]] = rmw_word;
            rmw_pend = 1'b0;
            return;
        end

`ifdef CPRV_ARB_RR_EN
        gd = dv && !(ifv && last_d);
`else
        gd = dv;
`endif
        acc_d = dv && gd;
        acc_f = ifv && !gd;
        checkOutput("ready_exclusive", {63'd0, if_req_ready && d_req_ready}, 64'd0);
        if (dv)  checkOutput("d_ready", {63'd0, d_req_ready}, {63'd0, gd});
        if (ifv) checkOutput("if_ready", {63'd0, if_req_ready}, {63'd0, !gd});

        full_wr = acc_d && we && (ws == 8'hFF);
        part_wr = acc_d && we && (ws != 8'h00) && (ws != 8'hFF);
        checkOutput("w_en", {63'd0, mem_w_en}, {63'd0, full_wr});

        if (acc_d || acc_f) begin
            checkOutput("acc_addr", {57'd0, mem_addr}, {57'd0, acc_d ? da : ifa});
            last_d   = acc_d;
            rsp_is_d = acc_d;
            cur      = ref_mem[acc_d ? da[6:3] : ifa[6:3]];
            if (full_wr) begin
                checkOutput("full_wdata", mem_wdata, wd);
                ref_mem[da[6:3]] = wd;
                rsp_word = wd;
                rsp_cnt  = 1;
            end else if (part_wr) begin
                rmw_word = mergeBytes(cur, wd, ws);
                rmw_addr = da;
                rmw_pend = 1'b1;
                rsp_word = rmw_word;
                rsp_cnt  = 2;
            end else begin
                rsp_word = cur;
                rsp_cnt  = 1;
            end
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0);
    endtask

    initial begin
        logic [7:0] ws;
        int         sel;

        $display("[TB] start");
        applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0);
        applyStimulus(1'b1, 1'b1, 7'd0, 1'b1, 1'b0, 7'd0, 64'd0, 8'd0);

        // Fetch read of a word holding 0x13.
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'h08, 64'h13, 8'hFF);
        idleCycle();
        applyStimulus(1'b0, 1'b1, 7'h08, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0);
        idleCycle();
        checkOutput("fetch_v", {63'd0, if_rsp_valid}, 64'd1);
        checkOutput("fetch_data", if_rsp_data, 64'h13);
        checkOutput("fetch_d_quiet", {63'd0, d_rsp_valid}, 64'd0);

        // Full write.
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'h10, 64'h1122334455667788, 8'hFF);
        checkOutput("fw_w_en", {63'd0, mem_w_en}, 64'd1);
        checkOutput("fw_wdata", mem_wdata, 64'h1122334455667788);
        idleCycle();
        checkOutput("fw_rsp", d_rsp_data, 64'h1122334455667788);

        // Partial write merges low half of zero into an all-ones word.
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'h18, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        idleCycle();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'h18, 64'h0, 8'h0F);
        checkOutput("pw_acc_w_en", {63'd0, mem_w_en}, 64'd0);
        idleCycle();
        checkOutput("pw_rmw_w_en", {63'd0, mem_w_en}, 64'd1);
        checkOutput("pw_rmw_wdata", mem_wdata, 64'hFFFFFFFF00000000);
        checkOutput("pw_rmw_no_rsp", {63'd0, d_rsp_valid}, 64'd0);
        idleCycle();
        checkOutput("pw_rsp_v", {63'd0, d_rsp_valid}, 64'd1);
        checkOutput("pw_rsp_data", d_rsp_data, 64'hFFFFFFFF00000000);

        // Both ports valid for four consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 7'h08, 1'b1, 1'b0, 7'h10, 64'd0, 8'd0);
`ifndef CPRV_ARB_RR_EN
            checkOutput("conflict_grant_d", {63'd0, d_req_ready}, 64'd1);
`endif
        end
        idleCycle();

        // Back-to-back fetches.
        applyStimulus(1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0);
        applyStimulus(1'b0, 1'b1, 7'h04, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0);
        checkOutput("b2b_rsp0", {63'd0, if_rsp_valid}, 64'd1);
        applyStimulus(1'b0, 1'b1, 7'h08, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0);
        checkOutput("b2b_rsp1", {63'd0, if_rsp_valid}, 64'd1);
        idleCycle();
        checkOutput("b2b_rsp2", if_rsp_data, 64'h13);

        // Reset landing on the write-back cycle of a partial write.
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        idleCycle();
        applyStimulus(1'b0, 1'b0, 7'd0, 1'b1, 1'b1, 7'h20, 64'h0123456789ABCDEF, 8'h0F);
        applyStimulus(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0);
        idleCycle();
        checkOutput("rst_rmw_mem", tb_mem[4], 64'hFFFFFFFFFFFFFFFF);
        applyStimulus(1'b0, 1'b1, 7'h20, 1'b0, 1'b0, 7'd0, 64'd0, 8'd0);
        idleCycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 3);
            ws  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
            applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), 7'($urandom),
                          1'($urandom), 1'($urandom), 7'($urandom),
                          {32'($urandom), 32'($urandom)}, ws);
        end
        idleCycle();
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
